// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide sequencer that sits beside the ALU in EX.
// It takes one mult/multu/div/divu op at a time and holds Busy for that op's fixed
// latency. It then commits the 64-bit result to HI/LO and pulses Done for one cycle.
// mthi/mtlo write HI or LO directly at the next edge.
//
// Ports:
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   Start, MDOp[2:0] issue strobe and op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   SrcA, SrcB[31:0] rs / rt operands
//   Cancel           abort the in-flight op (EX flush); also squashes a same-cycle Start
//   Busy             op in flight (registered)
//   Done             one-cycle pulse on the cycle HI/LO take a mult/div result
//   HI, LO[31:0]     architectural HI/LO registers
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Cancel,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   pend_h, pend_h_nxt, pend_l, pend_l_nxt;
  logic [31:0]   hi, hi_nxt, lo, lo_nxt;
  logic          busy, busy_nxt, done, done_nxt;
  logic [63:0]   md_res;

  // The full result is computed in the issue cycle and parked in pend_h/pend_l.
  // The counter only models the latency seen by the rest of the pipeline.
  logic signed [63:0] sa64, sb64, sprod;
  logic signed [31:0] squo, srem;
  always_comb begin
    sa64   = $signed({{32{SrcA[31]}}, SrcA});
    sb64   = $signed({{32{SrcB[31]}}, SrcB});
    sprod  = sa64 * sb64;
    squo   = '0;
    srem   = '0;
    md_res = '0;
    case (MDOp[1:0])
      2'd0: md_res = sprod;
      2'd1: md_res = {32'd0, SrcA} * {32'd0, SrcB};
      2'd2: begin
        if (SrcB == 32'd0)
          md_res = {SrcA, 32'hFFFF_FFFF};
        else if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF)
          md_res = {32'd0, 32'h8000_0000};   // quotient overflows; wrap, no trap
        else begin
          squo   = $signed(SrcA) / $signed(SrcB);
          srem   = $signed(SrcA) % $signed(SrcB);
          md_res = {srem, squo};
        end
      end
      default: begin
        if (SrcB == 32'd0) md_res = {SrcA, 32'hFFFF_FFFF};
        else               md_res = {SrcA % SrcB, SrcA / SrcB};
      end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pend_h_nxt = pend_h;
    pend_l_nxt = pend_l;
    hi_nxt     = hi;
    lo_nxt     = lo;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // Cancel in the issue cycle means the EX op is being flushed: squash it.
        if (Start && !Cancel) begin
          case (MDOp)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              pend_h_nxt = md_res[63:32];
              pend_l_nxt = md_res[31:0];
              cnt_nxt    = MDOp[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
              state_nxt  = RUN;
              busy_nxt   = 1'b1;
            end
            3'd4:    hi_nxt = SrcA;
            3'd5:    lo_nxt = SrcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Start is ignored here; the hazard unit never issues while Busy.
        if (Cancel) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else if (cnt == '0) begin
          hi_nxt    = pend_h;
          lo_nxt    = pend_l;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend_h <= '0;
      pend_l <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend_h <= pend_h_nxt;
      pend_l <= pend_l_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  assign Busy = busy;
  assign Done = done;
  assign HI   = hi;
  assign LO   = lo;

endmodule
